// File: rtl/life_cell_update_pkg.sv
// Shared constants, default rule masks and FSM state type for the life cell block.
// Default masks encode Conway's rules: birth on 3, survival on 2 or 3.
package life_pkg;

  localparam int COUNT_W       = 4;
  localparam int MAX_NEIGHBORS = 8;
  localparam int AGE_W         = 8;

  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_NEIGHBORS);

  localparam logic [MAX_NEIGHBORS:0] DEFAULT_BIRTH_MASK   = 9'b000001000;
  localparam logic [MAX_NEIGHBORS:0] DEFAULT_SURVIVE_MASK = 9'b000001100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/life_cell_update_if.sv
// Step/load handshake and cell status bundle between a controller and one life cell.
interface life_cell_update_if;
  import life_pkg::*;

  logic [COUNT_W-1:0] neighbor_count;
  logic               step_valid;
  logic               step_ready;
  logic               load_en;
  logic               load_value;
  logic               alive;
  logic               done;
  logic               changed;
  logic               count_err;
  logic [AGE_W-1:0]   age;

  modport master (
    output neighbor_count, step_valid, load_en, load_value,
    input  step_ready, alive, done, changed, count_err, age
  );

  modport slave (
    input  neighbor_count, step_valid, load_en, load_value,
    output step_ready, alive, done, changed, count_err, age
  );

endinterface

// File: rtl/life_cell_update_rule.sv
// Combinational birth/survival lookup; a count above the neighbourhood size indexes as 0.
module life_rule
  import life_pkg::*;
(
  input  logic                   alive,
  input  logic [COUNT_W-1:0]     count,
  input  logic [MAX_NEIGHBORS:0] birth_mask,
  input  logic [MAX_NEIGHBORS:0] survive_mask,
  output logic                   next
);

  logic [COUNT_W-1:0] idx;

  always_comb begin
    idx  = (count > MAX_COUNT) ? '0 : count;
    next = alive ? survive_mask[idx] : birth_mask[idx];
  end

endmodule

// File: rtl/life_cell_update.sv
// Single Game-of-Life cell: IDLE -> EVAL -> COMMIT step FSM with seed load and error flag.
// Optional age counter is built only when LIFE_CELL_AGE_EN is defined.
module life_cell_update
  import life_pkg::*;
#(
  parameter logic [MAX_NEIGHBORS:0] BIRTH_MASK   = DEFAULT_BIRTH_MASK,
  parameter logic [MAX_NEIGHBORS:0] SURVIVE_MASK = DEFAULT_SURVIVE_MASK
) (
  input  logic               clk,
  input  logic               rst_n,
  life_cell_update_if.slave  bus
);

  state_t             state_q;
  state_t             state_d;
  logic [COUNT_W-1:0] cnt_q;
  logic               result_q;
  logic               rule_next;
  logic               alive_q;
  logic               done_q;
  logic               changed_q;
  logic               err_q;
  logic               accept;
  logic               commit;

  // A load always takes priority, so it blocks acceptance and cancels a pending commit
  assign accept = (state_q == IDLE) && bus.step_valid && !bus.load_en;
  assign commit = (state_q == COMMIT) && !bus.load_en;

  life_rule u_rule (
    .alive        (alive_q),
    .count        (cnt_q),
    .birth_mask   (BIRTH_MASK),
    .survive_mask (SURVIVE_MASK),
    .next         (rule_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EVAL;
      EVAL:    state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.load_en) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      result_q  <= 1'b0;
      alive_q   <= 1'b0;
      done_q    <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      changed_q <= 1'b0;
      if (accept) begin
        cnt_q <= bus.neighbor_count;
        if (bus.neighbor_count > MAX_COUNT) err_q <= 1'b1;
      end
      if (state_q == EVAL) result_q <= rule_next;
      if (bus.load_en) begin
        alive_q <= bus.load_value;
      end else if (commit) begin
        alive_q   <= result_q;
        done_q    <= 1'b1;
        changed_q <= (result_q != alive_q);
      end
    end
  end

`ifdef LIFE_CELL_AGE_EN
  logic [AGE_W-1:0] age_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else if (bus.load_en) begin
      age_q <= '0;
    end else if (commit) begin
      if (!result_q)        age_q <= '0;
      else if (age_q != '1) age_q <= age_q + 1'b1;
    end
  end

  assign bus.age = age_q;
`else
  assign bus.age = '0;
`endif

  assign bus.step_ready = (state_q == IDLE);
  assign bus.alive      = alive_q;
  assign bus.done       = done_q;
  assign bus.changed    = changed_q;
  assign bus.count_err  = err_q;

endmodule

// File: tb/tb_life_cell_update.sv
// Directed self-checking bench for life_cell_update; age expectations follow LIFE_CELL_AGE_EN.
module tb_life_cell_update;
  import life_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef LIFE_CELL_AGE_EN
  localparam bit AGE_ON = 1'b1;
`else
  localparam bit AGE_ON = 1'b0;
`endif

  life_cell_update_if bus ();

  life_cell_update dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_age(int n);
    if (!AGE_ON) return 8'd0;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  task automatic check_output(string tag, logic [7:0] observed, logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(logic step, logic [3:0] cnt, logic ld, logic ldv);
    bus.step_valid     = step;
    bus.neighbor_count = cnt;
    bus.load_en        = ld;
    bus.load_value     = ldv;
  endtask

  task automatic load_cell(string tag, logic v);
    apply_stimulus(1'b0, 4'd0, 1'b1, v);
    tick();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    check_output({tag, ".alive"}, bus.alive, v);
    check_output({tag, ".done"}, bus.done, 1'b0);
    check_output({tag, ".age"}, bus.age, 8'd0);
  endtask

  // Inputs change right after the accept edge to show only the accepted count matters
  task automatic run_step(string tag, logic [3:0] cnt, logic exp_alive,
                          logic exp_changed, logic [7:0] exp_age_v);
    check_output({tag, ".ready_in"}, bus.step_ready, 1'b1);
    apply_stimulus(1'b1, cnt, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, ~cnt, 1'b0, 1'b0);
    check_output({tag, ".ready_busy"}, bus.step_ready, 1'b0);
    check_output({tag, ".done_k"}, bus.done, 1'b0);
    check_output({tag, ".chg_k"}, bus.changed, 1'b0);
    tick();
    check_output({tag, ".done_k1"}, bus.done, 1'b0);
    tick();
    check_output({tag, ".done_k2"}, bus.done, 1'b1);
    check_output({tag, ".changed"}, bus.changed, exp_changed);
    check_output({tag, ".alive"}, bus.alive, exp_alive);
    check_output({tag, ".age"}, bus.age, exp_age_v);
    check_output({tag, ".ready_out"}, bus.step_ready, 1'b1);
  endtask

  initial begin
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    #2;
    check_output("rst.alive", bus.alive, 1'b0);
    check_output("rst.done", bus.done, 1'b0);
    check_output("rst.changed", bus.changed, 1'b0);
    check_output("rst.err", bus.count_err, 1'b0);
    check_output("rst.age", bus.age, 8'd0);
    check_output("rst.ready", bus.step_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Birth from a dead cell
    load_cell("b.load", 1'b0);
    run_step("b.step3", 4'd3, 1'b1, 1'b1, exp_age(1));

    // Survive, survive, die of overcrowding
    load_cell("s.load", 1'b1);
    run_step("s.cnt2", 4'd2, 1'b1, 1'b0, exp_age(1));
    run_step("s.cnt3", 4'd3, 1'b1, 1'b0, exp_age(2));
    run_step("s.cnt4", 4'd4, 1'b0, 1'b1, exp_age(0));
    check_output("s.err", bus.count_err, 1'b0);

    // Age saturation over 256 surviving generations
    load_cell("sat.load", 1'b1);
    for (int i = 1; i <= 256; i++) begin
      run_step("sat", 4'd2, 1'b1, 1'b0, exp_age(i));
    end

    // Out-of-range count looks up as 0 and sets the sticky error
    load_cell("e.load", 1'b0);
    run_step("e.cnt9", 4'd9, 1'b0, 1'b0, exp_age(0));
    check_output("e.err_set", bus.count_err, 1'b1);
    run_step("e.cnt3", 4'd3, 1'b1, 1'b1, exp_age(1));
    run_step("e.cnt2", 4'd2, 1'b1, 1'b0, exp_age(2));
    check_output("e.err_sticky", bus.count_err, 1'b1);

    // Load during EVAL aborts a birth step
    load_cell("ae.load", 1'b0);
    apply_stimulus(1'b1, 4'd3, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    check_output("ae.ready", bus.step_ready, 1'b1);
    check_output("ae.alive", bus.alive, 1'b0);
    check_output("ae.done", bus.done, 1'b0);
    tick();
    check_output("ae.done_late", bus.done, 1'b0);
    check_output("ae.alive_late", bus.alive, 1'b0);

    // Load during COMMIT aborts a birth step
    apply_stimulus(1'b1, 4'd3, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    check_output("ac.done", bus.done, 1'b0);
    check_output("ac.alive", bus.alive, 1'b0);
    check_output("ac.ready", bus.step_ready, 1'b1);

    // Load and step together in IDLE: load wins, step dropped
    apply_stimulus(1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    check_output("ls.ready", bus.step_ready, 1'b1);
    check_output("ls.alive", bus.alive, 1'b0);
    tick();
    tick();
    check_output("ls.done", bus.done, 1'b0);
    check_output("ls.alive_late", bus.alive, 1'b0);

    // Asynchronous reset in the COMMIT cycle
    load_cell("rc.load", 1'b1);
    run_step("rc.pre", 4'd2, 1'b1, 1'b0, exp_age(1));
    apply_stimulus(1'b1, 4'd3, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rc.alive", bus.alive, 1'b0);
    check_output("rc.age", bus.age, 8'd0);
    check_output("rc.done", bus.done, 1'b0);
    check_output("rc.err", bus.count_err, 1'b0);
    check_output("rc.ready", bus.step_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_output("rc.ready_rel", bus.step_ready, 1'b1);
    check_output("rc.done_rel", bus.done, 1'b0);
    check_output("rc.alive_rel", bus.alive, 1'b0);

    // Birth scenario again after reset
    load_cell("b2.load", 1'b0);
    run_step("b2.step3", 4'd3, 1'b1, 1'b1, exp_age(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
